rd_ptr_ctrl: RTL and testbench

Read-side pointer controller for the async FIFO; the read-domain counterpart of the write pointer generator.
- Synchronizes the Gray-coded write pointer into rd_clk and advances the binary/Gray read pointer on accepted reads.
- Produces the memory read address and the registered empty, almost-empty, fill-level and underflow indications.
- Its rd_ptr_g output feeds the write-domain synchronizer that drives the write side's full logic.

---
 rtl/async_fifo_pkg.sv | 13 +
 rtl/rd_ptr_ctrl_if.sv | 22 ++
 rtl/ptr_sync.sv | 16 +
 rtl/rd_ptr_ctrl.sv | 48 ++++
 tb/tb_rd_ptr_ctrl.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/async_fifo_pkg.sv
// async_fifo_pkg: shared pointer defaults and Gray/binary conversion helpers
package async_fifo_pkg;
  localparam int ADDR_WIDTH_DEF = 4;
  localparam int SYNC_STAGES_DEF = 2;
  function automatic logic [31:0] bin_to_gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [31:0] gray_to_bin(input logic [31:0] g);
    logic [31:0] b;
    for (int i = 0; i < 32; i++) b[i] = ^(g >> i);
    return b;
  endfunction
endpackage

// File: rtl/rd_ptr_ctrl_if.sv
// rd_ptr_ctrl_if: read-side FIFO control bundle between pointer logic and its user
interface rd_ptr_ctrl_if import async_fifo_pkg::*; #(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] wr_ptr_g;
  logic [ADDR_WIDTH-2:0] rd_addr;
  logic [ADDR_WIDTH-1:0] rd_ptr_b;
  logic [ADDR_WIDTH-1:0] rd_ptr_g;
  logic                  fifo_empty;
  logic                  fifo_aempty;
  logic [ADDR_WIDTH-1:0] rd_level;
  logic                  underflow;
  modport master (
    output rd_en, wr_ptr_g,
    input  rd_addr, rd_ptr_b, rd_ptr_g, fifo_empty, fifo_aempty, rd_level, underflow
  );
  modport slave (
    input  rd_en, wr_ptr_g,
    output rd_addr, rd_ptr_b, rd_ptr_g, fifo_empty, fifo_aempty, rd_level, underflow
  );
endinterface

// File: rtl/ptr_sync.sv
// ptr_sync: multi-flop synchronizer for a Gray pointer crossing clock domains
module ptr_sync #(
  parameter int STAGES = 2,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [STAGES-1:0][WIDTH-1:0] sr;
  // shift the incoming pointer through the chain, cleared on reset
  always_ff @(posedge clk)
    sr <= rst ? '0 : {sr[STAGES-2:0], d};
  assign q = sr[STAGES-1];
endmodule

// File: rtl/rd_ptr_ctrl.sv
// rd_ptr_ctrl: read pointer, empty, almost-empty, level and underflow logic of the async FIFO
module rd_ptr_ctrl import async_fifo_pkg::*; #(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int AEMPTY_THRESH = 2
) (
  input logic         rd_clk,
  input logic         rd_rst,
  rd_ptr_ctrl_if.slave bus
);
  localparam logic [ADDR_WIDTH-1:0] AE_LIM = ADDR_WIDTH'(AEMPTY_THRESH);
  logic [ADDR_WIDTH-1:0] wr_ptr_g_sync, wr_ptr_b_sync, rd_ptr_b, rd_ptr_g, rd_ptr_b_next, level_next, rd_level;
  logic fifo_empty, fifo_aempty, underflow, acc;
  ptr_sync #(.STAGES(SYNC_STAGES), .WIDTH(ADDR_WIDTH)) u_sync (
    .clk(rd_clk),
    .rst(rd_rst),
    .d(bus.wr_ptr_g),
    .q(wr_ptr_g_sync)
  );
  assign acc = bus.rd_en && !fifo_empty;
  assign rd_ptr_b_next = rd_ptr_b + ADDR_WIDTH'(acc);
  assign wr_ptr_b_sync = ADDR_WIDTH'(gray_to_bin(32'(wr_ptr_g_sync)));
  assign level_next = wr_ptr_b_sync - rd_ptr_b_next;
  // advance pointers on accepted reads and register the status flags from the post-read state
  always_ff @(posedge rd_clk)
    if (rd_rst) begin
      rd_ptr_b <= '0;
      rd_ptr_g <= '0;
      rd_level <= '0;
      fifo_empty <= 1'b1;
      fifo_aempty <= 1'b1;
      underflow <= 1'b0;
    end else begin
      rd_ptr_b <= rd_ptr_b_next;
      rd_ptr_g <= ADDR_WIDTH'(bin_to_gray(32'(rd_ptr_b_next)));
      rd_level <= level_next;
      fifo_empty <= rd_ptr_b_next == wr_ptr_b_sync;
      fifo_aempty <= level_next <= AE_LIM;
      underflow <= bus.rd_en && fifo_empty;
    end
  assign bus.rd_addr = rd_ptr_b[ADDR_WIDTH-2:0];
  assign bus.rd_ptr_b = rd_ptr_b;
  assign bus.rd_ptr_g = rd_ptr_g;
  assign bus.rd_level = rd_level;
  assign bus.fifo_empty = fifo_empty;
  assign bus.fifo_aempty = fifo_aempty;
  assign bus.underflow = underflow;
endmodule

// File: tb/tb_rd_ptr_ctrl.sv
// tb_rd_ptr_ctrl: randomized and directed check of rd_ptr_ctrl against a write-count/read-count model
module tb_rd_ptr_ctrl;
  logic rd_clk = 1'b0;
  logic rd_rst = 1'b1;
  int total = 0;
  int bad = 0;
  int wcount = 0;
  int rtot = 0;
  int m_level = 0;
  bit m_empty = 1'b1;
  bit m_aempty = 1'b1;
  bit m_uf = 1'b0;
  int vq[$];
  always #5 rd_clk = ~rd_clk;
  rd_ptr_ctrl_if #(.ADDR_WIDTH(4)) bus ();
  rd_ptr_ctrl #(.ADDR_WIDTH(4), .SYNC_STAGES(2), .AEMPTY_THRESH(2)) dut (
    .rd_clk(rd_clk),
    .rd_rst(rd_rst),
    .bus(bus.slave)
  );
  function automatic int gray(int b);
    return b ^ (b >> 1);
  endfunction
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic set_w(int c);
    wcount = c;
    bus.wr_ptr_g = 4'(gray(c & 15));
  endtask
  task automatic tick();
    bit en = bus.rd_en;
    bit r = rd_rst;
    int w = wcount & 15;
    int v;
    @(posedge rd_clk);
    #1;
    if (r) begin
      rtot = 0;
      m_level = 0;
      m_empty = 1'b1;
      m_aempty = 1'b1;
      m_uf = 1'b0;
      vq = {};
      repeat (2) vq.push_back(0);
    end else begin
      v = vq.pop_front();
      vq.push_back(w);
      m_uf = en && m_empty;
      if (en && !m_empty) rtot++;
      m_level = (v - rtot) & 15;
      m_empty = m_level == 0;
      m_aempty = m_level <= 2;
    end
    check("ptr_b", bus.rd_ptr_b, rtot & 15);
    check("ptr_g", bus.rd_ptr_g, gray(rtot & 15));
    check("addr", bus.rd_addr, rtot & 7);
    check("empty", bus.fifo_empty, m_empty);
    check("aempty", bus.fifo_aempty, m_aempty);
    check("level", bus.rd_level, m_level);
    check("underflow", bus.underflow, m_uf);
  endtask
  initial begin
    bus.rd_en = 1'b0;
    set_w(0);
    rd_rst = 1'b1;
    tick();
    tick();
    rd_rst = 1'b0;
    check("rst_empty", bus.fifo_empty, 1);
    check("rst_level", bus.rd_level, 0);
    set_w(1);
    tick();
    tick();
    check("lat_hidden", bus.fifo_empty, 1);
    tick();
    check("lat_empty", bus.fifo_empty, 0);
    check("lat_level", bus.rd_level, 1);
    bus.rd_en = 1'b1;
    tick();
    check("rd1_ptr_b", bus.rd_ptr_b, 1);
    check("rd1_ptr_g", bus.rd_ptr_g, 1);
    check("rd1_empty", bus.fifo_empty, 1);
    repeat (2) begin
      tick();
      check("uf_on", bus.underflow, 1);
      check("uf_hold", bus.rd_ptr_b, 1);
    end
    bus.rd_en = 1'b0;
    tick();
    check("uf_off", bus.underflow, 0);
    rd_rst = 1'b1;
    set_w(0);
    tick();
    rd_rst = 1'b0;
    set_w(8);
    repeat (3) tick();
    check("full_level", bus.rd_level, 8);
    check("full_aempty", bus.fifo_aempty, 0);
    bus.rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("drain_level", bus.rd_level, 7 - i);
      check("drain_aempty", bus.fifo_aempty, (7 - i) <= 2);
    end
    check("drain_empty", bus.fifo_empty, 1);
    bus.rd_en = 1'b0;
    set_w(16);
    repeat (3) tick();
    bus.rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("wrap_addr", bus.rd_addr, i);
      tick();
    end
    bus.rd_en = 1'b0;
    tick();
    check("wrap_ptr_g", bus.rd_ptr_g, 0);
    check("wrap_empty", bus.fifo_empty, 1);
    rd_rst = 1'b1;
    set_w(0);
    tick();
    rd_rst = 1'b0;
    set_w(5);
    repeat (3) tick();
    check("mid_level", bus.rd_level, 5);
    bus.rd_en = 1'b1;
    rd_rst = 1'b1;
    tick();
    check("mid_rst_ptr", bus.rd_ptr_b, 0);
    check("mid_rst_empty", bus.fifo_empty, 1);
    rd_rst = 1'b0;
    bus.rd_en = 1'b0;
    tick();
    tick();
    check("mid_hidden", bus.rd_level, 0);
    tick();
    check("mid_reappear", bus.rd_level, 5);
    for (int i = 0; i < 1500; i++) begin
      bus.rd_en = $urandom_range(0, 2) != 0;
      if ($urandom_range(0, 149) == 0) begin
        rd_rst = 1'b1;
        set_w(0);
      end else begin
        rd_rst = 1'b0;
        if (wcount - rtot < 8 && $urandom_range(0, 1) == 1) set_w(wcount + 1);
      end
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
